// File: rtl/uart_file_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_file_loader                                           |
// | Description : Drives the iob_uart register port to receive a length-     |
// |               prefixed file and writes it as 32-bit words to memory.     |
// |               Optional ACK/NAK byte enabled by UART_LOADER_ACK_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef UART_CLK_FREQ
`define UART_CLK_FREQ 100000000
`endif
`ifndef UART_BAUD_RATE
`define UART_BAUD_RATE 115200
`endif

module uart_file_loader #(
    parameter int ADDR_W       = 32,
    parameter int MAX_SIZE     = 2**20,
    parameter int UART_DIV_VAL = `UART_CLK_FREQ / `UART_BAUD_RATE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] mem_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       file_size,
    output logic              uart_sel,
    output logic              uart_wr,
    output logic              uart_rd,
    output logic [2:0]        uart_addr,
    output logic [31:0]       uart_di,
    input  logic [31:0]       uart_do,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready
);

    localparam logic [2:0] c_ADDR_DIV        = 3'd1;
    localparam logic [2:0] c_ADDR_SOFT_RESET = 3'd2;
    localparam logic [2:0] c_ADDR_DATA       = 3'd3;
    localparam logic [2:0] c_ADDR_RXEN       = 3'd4;
    localparam logic [2:0] c_ADDR_READ_VALID = 3'd6;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_INIT  = 3'd1;
    localparam logic [2:0] c_ST_POLL  = 3'd2;
    localparam logic [2:0] c_ST_RDATA = 3'd3;
    localparam logic [2:0] c_ST_WRITE = 3'd4;
`ifdef UART_LOADER_ACK_EN
    localparam logic [2:0] c_ADDR_WRITE_WAIT = 3'd0;
    localparam logic [2:0] c_ST_ACK_POLL     = 3'd5;
    localparam logic [2:0] c_ST_ACK_WR       = 3'd6;
    logic r_nak;
`endif

    logic [2:0]  r_state;
    logic [1:0]  r_step;
    logic        r_phase;
    logic [7:0]  r_rdata;
    logic        r_in_size;
    logic [31:0] r_bytes;

    logic [31:0] w_size_full;
    logic [31:0] w_bytes_nxt;
    logic [1:0]  w_lane;
    logic        w_unused_do;

    assign w_size_full = {r_rdata, file_size[23:0]};
    assign w_bytes_nxt = r_bytes + 32'd1;
    assign w_lane      = r_bytes[1:0];
    assign w_unused_do = ^uart_do[31:8];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= c_ST_IDLE;
            r_step    <= 2'd0;
            r_phase   <= 1'b0;
            r_rdata   <= 8'd0;
            r_in_size <= 1'b0;
            r_bytes   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            file_size <= 32'd0;
            uart_sel  <= 1'b0;
            uart_wr   <= 1'b0;
            uart_rd   <= 1'b0;
            uart_addr <= 3'd0;
            uart_di   <= 32'd0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
`ifdef UART_LOADER_ACK_EN
            r_nak     <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state   <= c_ST_INIT;
                        r_step    <= 2'd0;
                        r_bytes   <= 32'd0;
                        r_in_size <= 1'b1;
                        busy      <= 1'b1;
                        file_size <= 32'd0;
                        mem_addr  <= mem_base;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'd0;
                        uart_sel  <= 1'b1;
                        uart_wr   <= 1'b1;
                        uart_addr <= c_ADDR_SOFT_RESET;
                        uart_di   <= 32'd1;
                    end
                end
                c_ST_INIT: begin
                    r_step <= r_step + 2'd1;
                    case (r_step)
                        2'd0: begin
                            uart_addr <= c_ADDR_SOFT_RESET;
                            uart_di   <= 32'd0;
                        end
                        2'd1: begin
                            uart_addr <= c_ADDR_DIV;
                            uart_di   <= 32'(UART_DIV_VAL);
                        end
                        2'd2: begin
                            uart_addr <= c_ADDR_RXEN;
                            uart_di   <= 32'd1;
                        end
                        default: begin
                            uart_wr   <= 1'b0;
                            uart_rd   <= 1'b1;
                            uart_addr <= c_ADDR_READ_VALID;
                            uart_di   <= 32'd0;
                            r_phase   <= 1'b0;
                            r_state   <= c_ST_POLL;
                        end
                    endcase
                end
                c_ST_POLL: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_rdata <= uart_do[7:0];
                    end else if (r_rdata[0]) begin
                        uart_addr <= c_ADDR_DATA;
                        r_state   <= c_ST_RDATA;
                    end
                end
                c_ST_RDATA: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_rdata <= uart_do[7:0];
                    end else if (r_in_size) begin
                        file_size[{w_lane, 3'b000} +: 8] <= r_rdata;
                        r_bytes <= w_bytes_nxt;
                        uart_addr <= c_ADDR_READ_VALID;
                        r_state   <= c_ST_POLL;
                        if (w_lane == 2'd3) begin
                            r_bytes   <= 32'd0;
                            r_in_size <= 1'b0;
                            // Oversize or empty file ends the load without touching memory
                            if (w_size_full > 32'(MAX_SIZE) || w_size_full == 32'd0) begin
`ifdef UART_LOADER_ACK_EN
                                r_nak     <= (w_size_full != 32'd0);
                                uart_addr <= c_ADDR_WRITE_WAIT;
                                r_state   <= c_ST_ACK_POLL;
`else
                                uart_sel  <= 1'b0;
                                uart_rd   <= 1'b0;
                                uart_addr <= 3'd0;
                                busy      <= 1'b0;
                                done      <= (w_size_full == 32'd0);
                                error     <= (w_size_full != 32'd0);
                                r_state   <= c_ST_IDLE;
`endif
                            end
                        end
                    end else begin
                        mem_wdata[{w_lane, 3'b000} +: 8] <= r_rdata;
                        mem_wstrb[w_lane] <= 1'b1;
                        r_bytes <= w_bytes_nxt;
                        if (w_lane == 2'd3 || w_bytes_nxt == file_size) begin
                            uart_sel  <= 1'b0;
                            uart_rd   <= 1'b0;
                            uart_addr <= 3'd0;
                            mem_valid <= 1'b1;
                            r_state   <= c_ST_WRITE;
                        end else begin
                            uart_addr <= c_ADDR_READ_VALID;
                            r_state   <= c_ST_POLL;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'd0;
                        mem_addr  <= mem_addr + ADDR_W'(4);
                        if (r_bytes == file_size) begin
`ifdef UART_LOADER_ACK_EN
                            r_nak     <= 1'b0;
                            uart_sel  <= 1'b1;
                            uart_rd   <= 1'b1;
                            uart_addr <= c_ADDR_WRITE_WAIT;
                            r_phase   <= 1'b0;
                            r_state   <= c_ST_ACK_POLL;
`else
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= c_ST_IDLE;
`endif
                        end else begin
                            uart_sel  <= 1'b1;
                            uart_rd   <= 1'b1;
                            uart_addr <= c_ADDR_READ_VALID;
                            r_phase   <= 1'b0;
                            r_state   <= c_ST_POLL;
                        end
                    end
                end
`ifdef UART_LOADER_ACK_EN
                c_ST_ACK_POLL: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_rdata <= uart_do[7:0];
                    end else if (!r_rdata[0]) begin
                        uart_rd   <= 1'b0;
                        uart_wr   <= 1'b1;
                        uart_addr <= c_ADDR_DATA;
                        uart_di   <= r_nak ? 32'h15 : 32'h06;
                        r_state   <= c_ST_ACK_WR;
                    end
                end
                c_ST_ACK_WR: begin
                    uart_sel  <= 1'b0;
                    uart_wr   <= 1'b0;
                    uart_addr <= 3'd0;
                    uart_di   <= 32'd0;
                    busy      <= 1'b0;
                    done      <= ~r_nak;
                    error     <= r_nak;
                    r_state   <= c_ST_IDLE;
                end
`endif
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_file_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_file_loader                                        |
// | Description : Directed bench with a small UART RX/TX model and memory    |
// |               write recorder for uart_file_loader.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_file_loader;

    localparam int         c_DIV    = 434;
    localparam int         c_MAX    = 2**20;
    localparam logic [2:0] c_A_WW   = 3'd0;
    localparam logic [2:0] c_A_DIV  = 3'd1;
    localparam logic [2:0] c_A_SRST = 3'd2;
    localparam logic [2:0] c_A_DATA = 3'd3;
    localparam logic [2:0] c_A_RXEN = 3'd4;
    localparam logic [2:0] c_A_RV   = 3'd6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mem_base = 32'd0;
    logic        busy, done, error;
    logic [31:0] file_size;
    logic        uart_sel, uart_wr, uart_rd;
    logic [2:0]  uart_addr;
    logic [31:0] uart_di, uart_do;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b1;

    int total = 0;
    int bad = 0;

    // UART model state
    logic [7:0] rx_mem [0:255];
    int rd_ptr = 0, rx_end = 0, ww_cnt = 0;
    bit dphase = 0, wphase = 0;
    // Observation log
    logic [31:0] mw_addr [0:63];
    logic [31:0] mw_data [0:63];
    logic [3:0]  mw_strb [0:63];
    int mw_cnt = 0, mv_seen = 0, done_cnt = 0, err_cnt = 0, tx_cnt = 0, srst_cnt = 0;
    logic [7:0] last_tx = 8'd0;

    uart_file_loader #(.ADDR_W(32), .MAX_SIZE(c_MAX), .UART_DIV_VAL(c_DIV)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mem_base(mem_base),
        .busy(busy), .done(done), .error(error), .file_size(file_size),
        .uart_sel(uart_sel), .uart_wr(uart_wr), .uart_rd(uart_rd),
        .uart_addr(uart_addr), .uart_di(uart_di), .uart_do(uart_do),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign uart_do = !(uart_sel && uart_rd)  ? 32'd0 :
                     (uart_addr == c_A_RV)   ? {31'd0, rd_ptr < rx_end} :
                     (uart_addr == c_A_DATA) ? {24'd0, rx_mem[rd_ptr % 256]} :
                     (uart_addr == c_A_WW)   ? {31'd0, (ww_cnt % 2) == 0} : 32'd0;

    always @(negedge clk) begin
        if (!resetn) begin
            dphase = 0;
            wphase = 0;
        end else begin
            if (mem_valid) mv_seen++;
            if (mem_valid && mem_ready) begin
                mw_addr[mw_cnt % 64] = mem_addr;
                mw_data[mw_cnt % 64] = mem_wdata;
                mw_strb[mw_cnt % 64] = mem_wstrb;
                mw_cnt++;
            end
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (uart_sel && uart_wr && uart_addr == c_A_DATA) begin
                tx_cnt++;
                last_tx = uart_di[7:0];
            end
            if (uart_sel && uart_wr && uart_addr == c_A_SRST && uart_di == 32'd1) srst_cnt++;
            if (uart_sel && uart_rd && uart_addr == c_A_DATA) begin
                if (dphase) rd_ptr++;
                dphase = !dphase;
            end
            if (uart_sel && uart_rd && uart_addr == c_A_WW) begin
                if (wphase) ww_cnt++;
                wphase = !wphase;
            end
        end
    end

    task automatic load_rx(input logic [31:0] size, input int n, input logic [63:0] payload);
        int b = rd_ptr;
        for (int i = 0; i < 4; i++) rx_mem[(b + i) % 256] = size[8*i +: 8];
        for (int i = 0; i < n; i++) rx_mem[(b + 4 + i) % 256] = payload[8*i +: 8];
        rx_end = b + 4 + n;
    endtask

    task automatic pulse_start(input logic [31:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        mem_base = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid} !== 7'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid}); end
        total++; if ({file_size, uart_di, mem_addr, mem_wdata} !== 128'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {file_size, uart_di, mem_addr, mem_wdata}); end
        total++; if ({uart_addr, mem_wstrb} !== 7'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", {uart_addr, mem_wstrb}); end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_init;
        logic [37:0] exp, got;
        rx_end = rd_ptr;
        pulse_start(32'h1000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                0: exp = {3'b110, c_A_SRST, 32'd1};
                1: exp = {3'b110, c_A_SRST, 32'd0};
                2: exp = {3'b110, c_A_DIV, 32'(c_DIV)};
                3: exp = {3'b110, c_A_RXEN, 32'd1};
                default: exp = {3'b101, c_A_RV, 32'd0};
            endcase
            got = {uart_sel, uart_wr, uart_rd, uart_addr, uart_di};
            total++; if (got !== exp) begin bad++; $display("FAIL init_cycle%0d: got %h want %h", k + 1, got, exp); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL init_busy: got %b want 1", busy); end
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_8byte;
        int m0 = mw_cnt, d0 = done_cnt, e0 = err_cnt, t0 = tx_cnt;
        bit ok;
        load_rx(32'd8, 8, 64'h8877665544332211);
        pulse_start(32'h1000);
        wait_end(ok);
        total++; if (!ok) begin bad++; $display("FAIL b8_timeout: got no end want end"); end
        total++; if (mw_cnt - m0 !== 2) begin bad++; $display("FAIL b8_nwrites: got %0d want 2", mw_cnt - m0); end
        total++; if ({mw_addr[m0 % 64], mw_data[m0 % 64], mw_strb[m0 % 64]} !== {32'h1000, 32'h44332211, 4'hF}) begin bad++; $display("FAIL b8_w0: got %h %h %h want 1000 44332211 f", mw_addr[m0 % 64], mw_data[m0 % 64], mw_strb[m0 % 64]); end
        total++; if ({mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64], mw_strb[(m0 + 1) % 64]} !== {32'h1004, 32'h88776655, 4'hF}) begin bad++; $display("FAIL b8_w1: got %h %h %h want 1004 88776655 f", mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64], mw_strb[(m0 + 1) % 64]); end
        total++; if (file_size !== 32'd8) begin bad++; $display("FAIL b8_size: got %0d want 8", file_size); end
        total++; if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin bad++; $display("FAIL b8_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b8_busy: got %b want 0", busy); end
`ifdef UART_LOADER_ACK_EN
        total++; if ({tx_cnt - t0, 24'd0, last_tx} !== {32'd1, 32'h06}) begin bad++; $display("FAIL b8_ack: got n=%0d byte=%h want 1 06", tx_cnt - t0, last_tx); end
`else
        total++; if (tx_cnt - t0 !== 0) begin bad++; $display("FAIL b8_notx: got %0d want 0", tx_cnt - t0); end
`endif
    endtask

    task automatic test_partial;
        int m0 = mw_cnt;
        bit ok;
        load_rx(32'd6, 6, 64'h0000FFEEDDCCBBAA);
        pulse_start(32'h2000);
        wait_end(ok);
        total++; if (!ok || mw_cnt - m0 !== 2) begin bad++; $display("FAIL part_nwrites: got %0d want 2", mw_cnt - m0); end
        total++; if ({mw_addr[m0 % 64], mw_data[m0 % 64], mw_strb[m0 % 64]} !== {32'h2000, 32'hDDCCBBAA, 4'hF}) begin bad++; $display("FAIL part_w0: got %h %h %h want 2000 ddccbbaa f", mw_addr[m0 % 64], mw_data[m0 % 64], mw_strb[m0 % 64]); end
        total++; if ({mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64], mw_strb[(m0 + 1) % 64]} !== {32'h2004, 32'h0000FFEE, 4'h3}) begin bad++; $display("FAIL part_w1: got %h %h %h want 2004 0000ffee 3", mw_addr[(m0 + 1) % 64], mw_data[(m0 + 1) % 64], mw_strb[(m0 + 1) % 64]); end
    endtask

    task automatic test_backpressure;
        int viol = 0, d0 = done_cnt;
        bit seen = 0, ok;
        mem_ready = 1'b0;
        load_rx(32'd4, 4, 64'h04030201);
        pulse_start(32'h4000);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = mem_valid;
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_valid: got 0 want 1"); end
        for (int i = 0; i < 20; i++) begin
            if (!(mem_valid === 1'b1 && mem_addr === 32'h4000 && mem_wdata === 32'h04030201 && mem_wstrb === 4'hF && uart_sel === 1'b0)) viol++;
            @(negedge clk);
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d bad cycles want 0", viol); end
        #1 mem_ready = 1'b1;
        wait_end(ok);
        total++; if (!ok || done_cnt - d0 !== 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_zero;
        int v0 = mv_seen, d0 = done_cnt, e0 = err_cnt;
        bit ok;
        load_rx(32'd0, 0, 64'd0);
        pulse_start(32'h5000);
        wait_end(ok);
        total++; if (!ok || {done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin bad++; $display("FAIL zero_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
        total++; if (mv_seen - v0 !== 0) begin bad++; $display("FAIL zero_novalid: got %0d want 0", mv_seen - v0); end
    endtask

    task automatic test_oversize;
        int v0 = mv_seen, d0 = done_cnt, e0 = err_cnt;
        bit ok;
        load_rx(32'(c_MAX + 1), 0, 64'd0);
        pulse_start(32'h6000);
        wait_end(ok);
        total++; if (!ok || {done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd1}) begin bad++; $display("FAIL over_pulses: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0); end
        total++; if (mv_seen - v0 !== 0) begin bad++; $display("FAIL over_novalid: got %0d want 0", mv_seen - v0); end
        total++; if (file_size !== 32'h00100001) begin bad++; $display("FAIL over_size: got %h want 00100001", file_size); end
`ifdef UART_LOADER_ACK_EN
        total++; if (last_tx !== 8'h15) begin bad++; $display("FAIL over_nak: got %h want 15", last_tx); end
`endif
    endtask

    task automatic test_start_busy;
        int m0 = mw_cnt, s0 = srst_cnt, d0 = done_cnt;
        bit ok;
        load_rx(32'd4, 4, 64'hCAFEF00D);
        pulse_start(32'h3000);
        repeat (10) @(negedge clk);
        pulse_start(32'h7000);
        wait_end(ok);
        total++; if (!ok || srst_cnt - s0 !== 1) begin bad++; $display("FAIL busy_restart: got %0d inits want 1", srst_cnt - s0); end
        total++; if (mw_cnt - m0 !== 1 || mw_addr[m0 % 64] !== 32'h3000 || mw_data[m0 % 64] !== 32'hCAFEF00D) begin bad++; $display("FAIL busy_write: got n=%0d %h %h want 1 3000 cafef00d", mw_cnt - m0, mw_addr[m0 % 64], mw_data[m0 % 64]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_midreset;
        bit seen = 0;
        mem_ready = 1'b0;
        load_rx(32'd8, 8, 64'h8877665544332211);
        pulse_start(32'h1000);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = mem_valid;
        end
        total++; if (!seen) begin bad++; $display("FAIL mr_valid: got 0 want 1"); end
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if ({busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid} !== 7'd0) begin bad++; $display("FAIL mr_ctrl: got %b want 0", {busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid}); end
        total++; if ({file_size, uart_di, mem_addr, mem_wdata, uart_addr, mem_wstrb} !== 135'd0) begin bad++; $display("FAIL mr_data: got %h want 0", {file_size, uart_di, mem_addr, mem_wdata, uart_addr, mem_wstrb}); end
        @(posedge clk); #1;
        resetn = 1'b1;
        mem_ready = 1'b1;
        test_8byte();
    endtask

    initial begin
        test_reset();
        test_init();
        test_8byte();
        test_partial();
        test_backpressure();
        test_zero();
        test_oversize();
        test_start_busy();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
